axis_ln_convert: RTL and testbench

Pipelined natural-log converter for the RPSPMC control-source path. Accepts the offset-removed, rectified, zero-guarded magnitude stream (the `M_AXIS_ABS` output of the control-source selector) and returns a signed fixed-point ln(x) stream. That stream feeds the selector's `S_AXIS_LN` input for log-mode feedback (e.g. STM current). Throughput is one sample per clock, with fixed latency.

---
 rtl/axis_ln_convert_if.sv | 17 +
 rtl/axis_ln_convert.sv | 176 +++++++++++++++++
 tb/tb_axis_ln_convert.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_ln_convert_if.sv
// -----------------------------------------------------------------------------
// axis_ln_convert_if
// Streaming data bundle used on both sides of axis_ln_convert. There is no
// tready: a beat is transferred on every clock where tvalid is high.
//   tdata  [31:0] : sample payload
//   tvalid        : sample strobe
// Modports:
//   master : drives tdata/tvalid
//   slave  : receives tdata/tvalid
// -----------------------------------------------------------------------------
interface axis_ln_convert_if;
    logic [31:0] tdata;
    logic        tvalid;

    modport master (output tdata, output tvalid);
    modport slave  (input  tdata, input  tvalid);
endinterface

// File: rtl/axis_ln_convert.sv
// -----------------------------------------------------------------------------
// axis_ln_convert
// Five-stage pipelined natural-log converter. Takes an unsigned magnitude
// stream and returns ln(x) + ln_offset as signed Q7.24, saturated to 32 bits.
// One sample per clock, fixed latency of 5 clocks. The valid bit travels with
// its data; there is no state machine.
//
// Ports:
//   a_clk       in  : clock
//   a_resetn    in  : asynchronous active-low reset, flushes the pipeline
//   S_AXIS_ABS  slv : unsigned magnitude in (tdata integer LSB, tvalid)
//   M_AXIS_LN   mst : signed Q7.24 ln(x) + ln_offset out (tdata, tvalid)
//   ln_offset   in  : signed Q7.24 offset, sampled in the last stage
//   zero_flag   out : high with an output sample whose input was 0
//
// Build option:
//   AXIS_LN_INTERP_EN defined   : linear interpolation between LUT entries
//   AXIS_LN_INTERP_EN undefined : truncated-segment lookup only
// -----------------------------------------------------------------------------
module axis_ln_convert #(
    parameter int          LUT_ADDR_BITS = 6,
    parameter logic [31:0] LN2_Q24       = 32'd11629080
) (
    input  logic                     a_clk,
    input  logic                     a_resetn,
    axis_ln_convert_if.slave         S_AXIS_ABS,
    axis_ln_convert_if.master        M_AXIS_LN,
    input  logic [31:0]              ln_offset,
    output logic                     zero_flag
);

    localparam int NSEG  = 1 << LUT_ADDR_BITS;
    localparam int LUT_W = 17;
`ifdef AXIS_LN_INTERP_EN
    localparam int DW    = 16 - LUT_ADDR_BITS;
    localparam int MW    = LUT_W + DW;
`endif
    localparam logic signed [33:0] R_MAX = 34'sd2147483647;
    localparam logic signed [33:0] R_MIN = -34'sd2147483648;

    // round(log2(1 + k/NSEG) * 2^16), evaluated at elaboration only.
    // Bitwise log2 by repeated squaring with 62 fractional bits keeps the
    // 40-bit result far more precise than the final rounding step needs.
    function automatic logic [LUT_W-1:0] lut_entry(input int k);
        logic [127:0] y;
        logic [39:0]  r;
        logic [40:0]  rr;
        if (k >= NSEG) return LUT_W'(65536);
        y = 128'(NSEG + k) << (62 - LUT_ADDR_BITS);
        r = '0;
        for (int b = 39; b >= 0; b--) begin
            y = (y * y) >> 62;
            if (y[63]) begin
                y    = y >> 1;
                r[b] = 1'b1;
            end
        end
        rr = {1'b0, r} + (41'd1 << 23);
        return rr[40:24];
    endfunction

    function automatic logic [(NSEG+1)*LUT_W-1:0] build_lut();
        logic [(NSEG+1)*LUT_W-1:0] t;
        t = '0;
        for (int k = 0; k <= NSEG; k++) t[k*LUT_W +: LUT_W] = lut_entry(k);
        return t;
    endfunction

    localparam logic [(NSEG+1)*LUT_W-1:0] LUT = build_lut();

    function automatic logic [LUT_W-1:0] lut_at(input int k);
        return LUT[k*LUT_W +: LUT_W];
    endfunction

    // S1
    logic [31:0]              x1_q;
    logic                     v1_q, z1_q;
    // S2
    logic [4:0]               p_d, sh_d, p2_q;
    logic [LUT_ADDR_BITS-1:0] i_d, i2_q;
    logic                     v2_q, z2_q;
    // S3
    logic [LUT_W-1:0]         lo_d, lo3_q;
    logic [4:0]               p3_q;
    logic                     v3_q, z3_q;
`ifdef AXIS_LN_INTERP_EN
    logic [DW-1:0]            d_d, d2_q, d3_q;
    logic [LUT_W-1:0]         hi_d, hi3_q, span_d;
    logic [MW-1:0]            mul_d;
`endif
    // S4
    logic [LUT_W-1:0]         l_d;
    logic [21:0]              g_d, g4_q;
    logic                     v4_q, z4_q;
    // S5
    logic signed [33:0]       r_d;
    logic [31:0]              out_d, out_q;
    logic                     v5_q, zf_q;

    // S2: leading-one position and normalized mantissa fraction
    always_comb begin
        p_d = '0;
        for (int b = 0; b < 32; b++) if (x1_q[b]) p_d = 5'(b);
        sh_d = 5'd31 - p_d;
        i_d  = LUT_ADDR_BITS'((x1_q << sh_d) >> (31 - LUT_ADDR_BITS));
`ifdef AXIS_LN_INTERP_EN
        d_d  = DW'((x1_q << sh_d) >> 15);
`endif
        if (z1_q) begin
            p_d = '0;
            i_d = '0;
`ifdef AXIS_LN_INTERP_EN
            d_d = '0;
`endif
        end
    end

    // S3: ROM reads
    always_comb begin
        lo_d = lut_at(int'(i2_q));
`ifdef AXIS_LN_INTERP_EN
        hi_d = lut_at(int'(i2_q) + 1);
`endif
    end

    // S4: segment value (optionally interpolated) plus integer exponent
    always_comb begin
`ifdef AXIS_LN_INTERP_EN
        span_d = hi3_q - lo3_q;
        mul_d  = MW'(span_d) * MW'(d3_q);
        l_d    = lo3_q + LUT_W'(mul_d >> DW);
`else
        l_d    = lo3_q;
`endif
        g_d = 22'({p3_q, 16'h0000}) + 22'(l_d);
    end

    // S5: scale log2 to ln, add offset, saturate
    always_comb begin
        r_d = $signed({4'b0000, 30'((54'(g4_q) * 54'(LN2_Q24)) >> 16)})
            + 34'($signed(ln_offset));
        if (z4_q)              out_d = 32'h8000_0000;
        else if (r_d > R_MAX)  out_d = 32'h7FFF_FFFF;
        else if (r_d < R_MIN)  out_d = 32'h8000_0000;
        else                   out_d = r_d[31:0];
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            x1_q  <= '0;  v1_q <= 1'b0;  z1_q <= 1'b0;
            p2_q  <= '0;  i2_q <= '0;    v2_q <= 1'b0;  z2_q <= 1'b0;
            lo3_q <= '0;  p3_q <= '0;    v3_q <= 1'b0;  z3_q <= 1'b0;
            g4_q  <= '0;  v4_q <= 1'b0;  z4_q <= 1'b0;
            out_q <= '0;  v5_q <= 1'b0;  zf_q <= 1'b0;
`ifdef AXIS_LN_INTERP_EN
            d2_q  <= '0;  d3_q <= '0;    hi3_q <= '0;
`endif
        end else begin
            x1_q  <= S_AXIS_ABS.tdata;
            v1_q  <= S_AXIS_ABS.tvalid;
            z1_q  <= (S_AXIS_ABS.tdata == 32'd0);
            p2_q  <= p_d;   i2_q <= i_d;   v2_q <= v1_q;  z2_q <= z1_q;
            lo3_q <= lo_d;  p3_q <= p2_q;  v3_q <= v2_q;  z3_q <= z2_q;
            g4_q  <= g_d;   v4_q <= v3_q;  z4_q <= z3_q;
            out_q <= out_d; v5_q <= v4_q;  zf_q <= z4_q & v4_q;
`ifdef AXIS_LN_INTERP_EN
            d2_q  <= d_d;   d3_q <= d2_q;  hi3_q <= hi_d;
`endif
        end
    end

    assign M_AXIS_LN.tdata  = out_q;
    assign M_AXIS_LN.tvalid = v5_q;
    assign zero_flag        = zf_q;

endmodule

// File: tb/tb_axis_ln_convert.sv
module tb_axis_ln_convert;

    logic        a_clk    = 1'b0;
    logic        a_resetn = 1'b1;
    logic [31:0] ln_offset;
    logic        zero_flag;

    axis_ln_convert_if s_if ();
    axis_ln_convert_if m_if ();

    axis_ln_convert dut (
        .a_clk      (a_clk),
        .a_resetn   (a_resetn),
        .S_AXIS_ABS (s_if.slave),
        .M_AXIS_LN  (m_if.master),
        .ln_offset  (ln_offset),
        .zero_flag  (zero_flag)
    );

    always #5 a_clk = ~a_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge a_clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        zf;
        int          tol;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    // Reference LUT straight from the mathematical definition.
    function automatic int lut_ref(input int k);
        real v;
        v = $ln(1.0 + real'(k) / 64.0) / $ln(2.0) * 65536.0;
        return $rtoi($floor(v + 0.5));
    endfunction

    function automatic void model(input logic [31:0] x, input logic [31:0] off,
                                  output logic [31:0] y, output logic zf);
        int          p;
        logic [31:0] m;
        int          i, d;
        longint      l, g, prod, r;
        if (x == 32'd0) begin
            y  = 32'h8000_0000;
            zf = 1'b1;
            return;
        end
        zf = 1'b0;
        p  = 0;
        for (int b = 0; b < 32; b++) if (x[b]) p = b;
        m = x << (31 - p);
        i = int'(m[30:25]);
        d = int'(m[24:15]);
`ifdef AXIS_LN_INTERP_EN
        l = longint'(lut_ref(i) + (((lut_ref(i + 1) - lut_ref(i)) * d) >>> 10));
`else
        l = longint'(lut_ref(i));
        if (d < 0) l = 0;
`endif
        g    = longint'(p) * 65536 + l;
        prod = g * 64'sd11629080;
        r    = (prod >>> 16) + longint'($signed(off));
        if (r > 64'sd2147483647)       y = 32'h7FFF_FFFF;
        else if (r < -64'sd2147483648) y = 32'h8000_0000;
        else                           y = r[31:0];
    endfunction

    // Monitor: every output beat must match the oldest pending expectation.
    always @(negedge a_clk) begin
        exp_t   e;
        longint diff;
        if (a_resetn && m_if.tvalid) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_valid: observed tvalid=1 data=%h, required no pending sample", m_if.tdata);
            end
            if (sb.size() > 0) begin
                e    = sb.pop_front();
                diff = longint'($signed(m_if.tdata)) - longint'($signed(e.data));
                if (diff < 0) diff = -diff;
                checks++;
                assert (diff <= longint'(e.tol)) else begin
                    errors++;
                    $error("FAIL data: observed %h required %h (tol %0d)", m_if.tdata, e.data, e.tol);
                end
                checks++;
                assert (zero_flag === e.zf) else begin
                    errors++;
                    $error("FAIL zero_flag: observed %b required %b", zero_flag, e.zf);
                end
                checks++;
                assert ((cyc - e.cyc) === 5) else begin
                    errors++;
                    $error("FAIL latency: observed %0d required 5", cyc - e.cyc);
                end
            end
        end
    end

    task automatic drive(input logic [31:0] x, input logic v,
                         input logic [31:0] ed, input logic ezf, input int tol);
        @(posedge a_clk);
        #1;
        s_if.tdata  = x;
        s_if.tvalid = v;
        if (v) sb.push_back('{data: ed, zf: ezf, tol: tol, cyc: cyc});
    endtask

    task automatic drive_model(input logic [31:0] x, input logic v);
        logic [31:0] ed;
        logic        ezf;
        model(x, ln_offset, ed, ezf);
        drive(x, v, ed, ezf, 0);
    endtask

    task automatic drain();
        int n;
        @(posedge a_clk);
        #1;
        s_if.tvalid = 1'b0;
        n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(posedge a_clk);
            n++;
        end
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL drain_timeout: observed %0d pending, required 0", sb.size());
        end
        repeat (2) @(posedge a_clk);
    endtask

    task automatic check_idle(input string tag);
        checks++;
        assert (m_if.tdata === 32'd0) else begin
            errors++;
            $error("FAIL %s_tdata: observed %h required 00000000", tag, m_if.tdata);
        end
        checks++;
        assert (m_if.tvalid === 1'b0) else begin
            errors++;
            $error("FAIL %s_tvalid: observed %b required 0", tag, m_if.tvalid);
        end
        checks++;
        assert (zero_flag === 1'b0) else begin
            errors++;
            $error("FAIL %s_zero_flag: observed %b required 0", tag, zero_flag);
        end
    endtask

    task automatic random_stream(input int n);
        logic [31:0] x;
        logic        v;
        for (int k = 0; k < n; k++) begin
            x = $urandom() >> $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) x = 32'd0;
            v = ($urandom_range(0, 3) != 0);
            drive_model(x, v);
        end
    endtask

    initial begin
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        ln_offset   = '0;
        #1 a_resetn = 1'b0;
        #1 check_idle("reset");
        repeat (3) @(posedge a_clk);
        #2 a_resetn = 1'b1;

        // ln(1) = 0
        drive(32'd1, 1'b1, 32'h0000_0000, 1'b0, 0);
        drain();

        // ln(2) and 31*ln(2), back to back
        drive(32'd2,          1'b1, 32'h00B1_7218,  1'b0, 0);
        drive(32'h8000_0000,  1'b1, 32'd360501480,  1'b0, 0);
        drain();

        // ln(3) against the real function
        drive(32'd3, 1'b1, $rtoi($ln(3.0) * 16777216.0), 1'b0, 64);
        drain();

        // zero input ignores the offset
        ln_offset = 32'h0100_0000;
        drive(32'd0, 1'b1, 32'h8000_0000, 1'b1, 0);
        drain();

        // saturation at both ends
        ln_offset = 32'h7FFF_FFFF;
        drive(32'h8000_0000, 1'b1, 32'h7FFF_FFFF, 1'b0, 0);
        drain();
        ln_offset = 32'h8000_0000;
        drive(32'd1, 1'b1, 32'h8000_0000, 1'b0, 0);
        drain();

        // random stream with gaps
        ln_offset = 32'hFF80_0000;
        random_stream(60);
        drain();

        // reset in the middle of a stream
        ln_offset = 32'h0040_0000;
        for (int k = 0; k < 6; k++) drive_model($urandom() | 32'd1, 1'b1);
        @(posedge a_clk);
        #3;
        s_if.tvalid = 1'b0;
        a_resetn    = 1'b0;
        sb.delete();
        #1 check_idle("midreset");
        repeat (2) @(posedge a_clk);
        #2 a_resetn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge a_clk);
            #1;
            checks++;
            assert (m_if.tvalid === 1'b0) else begin
                errors++;
                $error("FAIL stale_valid: observed %b required 0", m_if.tvalid);
            end
        end

        // post-reset stream, including the first-beat latency
        random_stream(60);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
